usb_pattern_checker: RTL and testbench
======================================

# usb_pattern_checker

Downstream consumer for the USB test path. It drains a standard (non-FWFT) FIFO that is filled with the wrapping 0..MAX_VAL counting pattern, and checks every received word against the expected sequence. It reports words checked, errors, lock status and the first mismatch, for link-integrity testing of the USB interface.

## Interface
Parameters:
- N, 32, data word width.
- MAX_VAL, 255, last value of the counting pattern; the value after MAX_VAL is 0.
- CNT_W, 32, width of the word and error counters.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  enables FIFO reads.
- clr_i  input  1  synchronous clear of statistics and lock; single-cycle pulse.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_o  output  1  FIFO read strobe (combinational).
- fifo_data_i  input  N  FIFO read data, valid the cycle after fifo_rd_o.
- locked_o  output  1  high once the first word has been acquired.
- err_o  output  1  sticky; set on the first mismatch.
- word_cnt_o  output  CNT_W  number of words checked; wraps at 2^CNT_W.
- err_cnt_o  output  CNT_W  number of mismatches; saturates at all-ones.
- first_err_exp_o  output  N  expected value at the first mismatch.
- first_err_got_o  output  N  received value at the first mismatch.

## Operation
- Read strobe: fifo_rd_o = en_i & ~fifo_empty_i & ~rst_i & ~clr_i.
  - Never asserted while empty; throughput is 1 word/cycle.
- Internal rd_q register: rd_q <= fifo_rd_o.
  - rd_q high marks fifo_data_i as valid ("word event").
  - A word already in flight when en_i falls is still checked.
- next(x) = (x >= MAX_VAL) ? 0 : x + 1, computed at N bits.
- FSM, 2 states:
  - ACQ (reset state), on a word event:
    - exp <= next(data); word_cnt += 1; go to TRACK; locked_o <= 1.
    - No comparison is made on this word.
  - TRACK, on a word event:
    - word_cnt += 1.
    - If data == exp: exp <= next(exp).
    - If data != exp: err_cnt += 1 (saturating); err_o <= 1; exp <= next(data). This resync means a single dropped or extra word costs exactly one error.
    - If err_o was 0 before this event, capture first_err_exp_o <= exp and first_err_got_o <= data.
  - Data > MAX_VAL is compared like any other value, so it always mismatches.
- en_i low: no new reads; state, exp and statistics hold. Lock is kept across disable.
- clr_i (or rst_i):
  - State goes to ACQ; locked_o, err_o, both counters and both capture registers go to 0; rd_q goes to 0.
  - A word event coinciding with clr_i is discarded (not counted, not checked).
- rst_i has priority over clr_i, which has priority over a word event.

## Timing
- Reset values: fifo_rd_o 0, locked_o 0, err_o 0, word_cnt_o 0, err_cnt_o 0, first_err_exp_o 0, first_err_got_o 0; internal exp 0, rd_q 0.
- Cycle T: fifo_rd_o high. Cycle T+1: fifo_data_i valid, word event.
- All registered outputs reflect that word from cycle T+2 onward. Total latency is 2 cycles from read strobe to statistics.
- Back-to-back reads every cycle are sustained with no bubbles.
- Counter width rules:
  - word_cnt wraps modulo 2^CNT_W.
  - err_cnt holds at 2^CNT_W-1.
  - exp is N bits and never exceeds MAX_VAL after a match.
- Mid-stream empty gaps: fifo_rd_o drops in the same cycle fifo_empty_i rises; there is no effect on checking.

## Test plan
- Reset: hold rst_i 3 cycles with data pending -> fifo_rd_o 0 throughout; all outputs 0 after release until the first word.
- Continuous stream 0..255 then 0..9, en_i=1 -> locked_o=1 from 2 cycles after the first read; word_cnt_o=266; err_cnt_o=0; err_o=0.
- Stream starting at 100 (100..255, 0..20) -> acquires on 100; err_cnt_o=0; word_cnt_o=177.
- Dropped word, stream 5,6,8,9,10 -> err_cnt_o=1; first_err_exp_o=7; first_err_got_o=8; err_o=1; no further errors. Then a later 20,22 -> err_cnt_o=2 and capture registers stay 7/8.
- Random empty gaps plus en_i toggling on a correct 0..255 stream -> fifo_rd_o never high while fifo_empty_i=1; err_cnt_o=0; word_cnt_o=256.
- clr_i pulsed in the cycle a word (value 50) is valid, stream continuing 51,52 -> counters 0 and locked_o 0 the next cycle; 50 is not counted; reacquires on 51; word_cnt_o=2; err_cnt_o=0.

Source files
------------

// File: rtl/usb_pattern_checker_if.sv
// FIFO read port between a standard (non-FWFT) FIFO and its consumer.
// Handshake: the consumer raises fifo_rd_o only while fifo_empty_i is low; fifo_data_i is valid the cycle after.
interface usb_pattern_checker_if #(
  parameter int N = 32
) ();
  logic         fifo_empty_i;
  logic         fifo_rd_o;
  logic [N-1:0] fifo_data_i;

  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    output fifo_rd_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    input  fifo_rd_o
  );
endinterface

// File: rtl/usb_pattern_checker.sv
// Drains a FIFO carrying the wrapping 0..MAX_VAL counting pattern and checks each word.
// Reports words checked, errors, lock status and the first mismatch seen.
module usb_pattern_checker #(
  parameter int N       = 32,
  parameter int MAX_VAL = 255,
  parameter int CNT_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  usb_pattern_checker_if.master fifo,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      word_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [N-1:0]          first_err_exp_o,
  output logic [N-1:0]          first_err_got_o,
  output logic [0:0]            state_o
);

  localparam logic [0:0] ST_ACQ   = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [N-1:0] MAX_N = N'(MAX_VAL);

  logic [0:0]       state_q, state_d;
  logic             rd_q, rd_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [N-1:0]     exp_q, exp_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [N-1:0]     fexp_q, fexp_d;
  logic [N-1:0]     fgot_q, fgot_d;

  function automatic logic [N-1:0] next_val(input logic [N-1:0] x);
    return (x >= MAX_N) ? '0 : x + 1'b1;
  endfunction

  assign fifo.fifo_rd_o = en_i & ~fifo.fifo_empty_i & ~rst_i & ~clr_i;

  always_comb begin
    state_d    = state_q;
    rd_d       = fifo.fifo_rd_o;
    locked_d   = locked_q;
    err_d      = err_q;
    exp_d      = exp_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    fexp_d     = fexp_q;
    fgot_d     = fgot_q;
    if (clr_i) begin
      // A word landing in the clear cycle is dropped, not checked.
      state_d    = ST_ACQ;
      rd_d       = 1'b0;
      locked_d   = 1'b0;
      err_d      = 1'b0;
      exp_d      = '0;
      word_cnt_d = '0;
      err_cnt_d  = '0;
      fexp_d     = '0;
      fgot_d     = '0;
    end else if (rd_q) begin
      word_cnt_d = word_cnt_q + 1'b1;
      case (state_q)
        ST_ACQ: begin
          exp_d    = next_val(fifo.fifo_data_i);
          locked_d = 1'b1;
          state_d  = ST_TRACK;
        end
        default: begin
          if (fifo.fifo_data_i == exp_q) begin
            exp_d = next_val(exp_q);
          end else begin
            // Resync on the received word so one slip costs one error.
            exp_d = next_val(fifo.fifo_data_i);
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!err_q) begin
              fexp_d = exp_q;
              fgot_d = fifo.fifo_data_i;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ACQ;
      rd_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      exp_q      <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      fexp_q     <= '0;
      fgot_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      exp_q      <= exp_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fexp_q     <= fexp_d;
      fgot_q     <= fgot_d;
    end
  end

  assign locked_o        = locked_q;
  assign err_o           = err_q;
  assign word_cnt_o      = word_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_exp_o = fexp_q;
  assign first_err_got_o = fgot_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_usb_pattern_checker.sv
// Bench for usb_pattern_checker: a FIFO model feeds directed streams, snapshots of the
// expected status are queued by the stimulus and compared by an independent monitor.
module tb_usb_pattern_checker;

  localparam int N     = 32;
  localparam int CNT_W = 32;
  localparam int W     = 3 + 4 * 32;

  logic             clk;
  logic             rst_i;
  logic             en_i;
  logic             clr_i;
  logic             locked_o;
  logic             err_o;
  logic [CNT_W-1:0] word_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [N-1:0]     first_err_exp_o;
  logic [N-1:0]     first_err_got_o;
  logic [0:0]       state_o;

  usb_pattern_checker_if #(.N(N)) fifo_if ();

  usb_pattern_checker #(.N(N), .MAX_VAL(255), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .clr_i           (clr_i),
    .fifo            (fifo_if),
    .locked_o        (locked_o),
    .err_o           (err_o),
    .word_cnt_o      (word_cnt_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_exp_o (first_err_exp_o),
    .first_err_got_o (first_err_got_o),
    .state_o         (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [N-1:0] fifo_q[$];
  logic         gaps_on;

  initial begin
    fifo_if.fifo_empty_i = 1'b1;
    fifo_if.fifo_data_i  = '0;
  end

  always @(posedge clk) begin
    int sz;
    sz = fifo_q.size();
    if (fifo_if.fifo_rd_o && sz > 0) begin
      fifo_if.fifo_data_i <= fifo_q.pop_front();
      sz = sz - 1;
    end
    fifo_if.fifo_empty_i <= (sz == 0) || (gaps_on && ($urandom_range(0, 2) == 0));
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           snap_issued = 0;
  int           snap_done   = 0;
  int           checks      = 0;
  int           errors      = 0;

  function automatic logic [W-1:0] pack(input logic rd, input logic lk, input logic er,
                                        input logic [31:0] wc, input logic [31:0] ec,
                                        input logic [31:0] fe, input logic [31:0] fg);
    return {rd, lk, er, wc, ec, fe, fg};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic expect_snap(input string nm, input logic rd, input logic lk, input logic er,
                             input int wc, input int ec, input int fe, input int fg);
    exp_q.push_back(pack(rd, lk, er, wc, ec, fe, fg));
    name_q.push_back(nm);
    snap_issued++;
  endtask

  // Monitor: compares queued snapshots and watches the read strobe every cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    string        nm;
    #1;
    chk("rd_while_empty", {31'd0, fifo_if.fifo_rd_o & fifo_if.fifo_empty_i}, 32'd0);
    while (snap_done < snap_issued) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".fifo_rd"},   {31'd0, fifo_if.fifo_rd_o}, {31'd0, e[130]});
      chk({nm, ".locked"},    {31'd0, locked_o},          {31'd0, e[129]});
      chk({nm, ".err"},       {31'd0, err_o},             {31'd0, e[128]});
      chk({nm, ".word_cnt"},  word_cnt_o,                 e[127:96]);
      chk({nm, ".err_cnt"},   err_cnt_o,                  e[95:64]);
      chk({nm, ".first_exp"}, first_err_exp_o,            e[63:32]);
      chk({nm, ".first_got"}, first_err_got_o,            e[31:0]);
      snap_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) fifo_q.push_back(N'(v));
  endtask

  task automatic drain(input string nm);
    int cyc;
    cyc = 0;
    while ((fifo_q.size() != 0) && (cyc < 5000)) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL %s.drain_timeout got=%0d exp=0 words left", nm, fifo_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i   = 1'b1;
    en_i    = 1'b1;
    clr_i   = 1'b0;
    gaps_on = 1'b0;
    push_range(0, 3);

    // Reset held three cycles with data pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_snap("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_i = 1'b0;
    en_i  = 1'b0;
    expect_snap("reset_release", 0, 0, 0, 0, 0, 0, 0);
    fifo_q.delete();
    repeat (2) @(negedge clk);

    // Continuous 0..255 then 0..9, with lock latency checks.
    push_range(0, 255);
    push_range(0, 9);
    @(negedge clk);
    en_i = 1'b1;
    expect_snap("lock_t0", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_snap("lock_t1", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_snap("lock_t2", 1, 1, 0, 1, 0, 0, 0);
    drain("stream_wrap");
    expect_snap("stream_wrap", 0, 1, 0, 266, 0, 0, 0);

    // Acquisition mid-pattern.
    pulse_clr();
    push_range(100, 255);
    push_range(0, 20);
    drain("start_100");
    expect_snap("start_100", 0, 1, 0, 177, 0, 0, 0);

    // Dropped word, then a later second slip.
    pulse_clr();
    fifo_q.push_back(32'd5);
    fifo_q.push_back(32'd6);
    push_range(8, 10);
    drain("drop_one");
    expect_snap("drop_one", 0, 1, 1, 5, 1, 7, 8);
    push_range(11, 20);
    fifo_q.push_back(32'd22);
    drain("drop_two");
    expect_snap("drop_two", 0, 1, 1, 16, 2, 7, 8);

    // Random empty gaps and enable toggling over a clean stream.
    pulse_clr();
    gaps_on = 1'b1;
    push_range(0, 255);
    for (int i = 0; i < 4000 && fifo_q.size() != 0; i++) begin
      @(negedge clk);
      en_i = 1'($urandom_range(0, 1));
    end
    en_i = 1'b1;
    drain("gaps");
    gaps_on = 1'b0;
    repeat (2) @(negedge clk);
    expect_snap("gaps", 0, 1, 0, 256, 0, 0, 0);

    // Clear coincident with word 50 being valid.
    pulse_clr();
    en_i = 1'b0;
    push_range(50, 52);
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    expect_snap("clr_cycle", 1, 0, 0, 0, 0, 0, 0);
    drain("clr_reacq");
    expect_snap("clr_reacq", 0, 1, 0, 2, 0, 0, 0);

    // Let the monitor catch up, bounded.
    for (int i = 0; i < 20 && snap_done < snap_issued; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (snap_done != snap_issued) begin
      errors++;
      $display("FAIL monitor_backlog got=%0d exp=%0d", snap_done, snap_issued);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
